// File: rtl/cbp_dec_pkg.sv
// -----------------------------------------------------------------------------
// cbp_dec_pkg
//   Shared constants, FSM state encoding and the Exp-Golomb arithmetic helper
//   for the coded_block_pattern ue(v) decoder.
//
//   Contents:
//     CBP_MAX_LZ       default maximum number of Exp-Golomb prefix zeros
//     CBP_MAX_CODENUM  default largest legal intra 4x4 / 8x8 CBP codeNum
//     LZ_W             width of the prefix-zero and suffix-bit counters
//     CNT_W            width of the total consumed-bit counter
//     state_t          FSM states IDLE / PREFIX / SUFFIX / OUT
//     eg_codenum()     codeNum = (1 << lz) - 1 + suffix, in 6 bits
// -----------------------------------------------------------------------------
package cbp_dec_pkg;

    localparam int CBP_MAX_LZ      = 5;
    localparam int CBP_MAX_CODENUM = 47;

    // 3 bits covers lz up to 7, but the 6-bit codeNum path only holds the
    // result for lz <= 5, which is the largest prefix a CBP code can have.
    localparam int LZ_W  = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_SUFFIX = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // With lz <= 5 and suffix < 2^lz the result never exceeds 62, so the
    // whole computation fits in 6 bits without a wider intermediate.
    function automatic logic [5:0] eg_codenum(input logic [LZ_W-1:0] lz,
                                              input logic [4:0]      suffix);
        return (6'd1 << lz) - 6'd1 + {1'b0, suffix};
    endfunction

endpackage

// File: rtl/cbp_dec_lut.sv
// -----------------------------------------------------------------------------
// cbp_dec_lut
//   Combinational codeNum -> coded_block_pattern map for intra 4x4 / 8x8
//   macroblocks (chroma present). This is the exact inverse of the encoder's
//   intra CBP -> codeNum table. codeNums above 47 map to 0.
//
//   Ports:
//     codenum_i  in  [5:0]  decoded Exp-Golomb codeNum
//     cbp_o      out [5:0]  coded_block_pattern, [3:0] luma, [5:4] chroma
// -----------------------------------------------------------------------------
module cbp_dec_lut (
    input  logic [5:0] codenum_i,
    output logic [5:0] cbp_o
);

    always_comb begin
        cbp_o = 6'd0;
        case (codenum_i)
            6'd0:  cbp_o = 6'd47;  6'd1:  cbp_o = 6'd31;  6'd2:  cbp_o = 6'd15;
            6'd3:  cbp_o = 6'd0;   6'd4:  cbp_o = 6'd23;  6'd5:  cbp_o = 6'd27;
            6'd6:  cbp_o = 6'd29;  6'd7:  cbp_o = 6'd30;  6'd8:  cbp_o = 6'd7;
            6'd9:  cbp_o = 6'd11;  6'd10: cbp_o = 6'd13;  6'd11: cbp_o = 6'd14;
            6'd12: cbp_o = 6'd39;  6'd13: cbp_o = 6'd43;  6'd14: cbp_o = 6'd45;
            6'd15: cbp_o = 6'd46;  6'd16: cbp_o = 6'd16;  6'd17: cbp_o = 6'd3;
            6'd18: cbp_o = 6'd5;   6'd19: cbp_o = 6'd10;  6'd20: cbp_o = 6'd12;
            6'd21: cbp_o = 6'd19;  6'd22: cbp_o = 6'd21;  6'd23: cbp_o = 6'd26;
            6'd24: cbp_o = 6'd28;  6'd25: cbp_o = 6'd35;  6'd26: cbp_o = 6'd37;
            6'd27: cbp_o = 6'd42;  6'd28: cbp_o = 6'd44;  6'd29: cbp_o = 6'd1;
            6'd30: cbp_o = 6'd2;   6'd31: cbp_o = 6'd4;   6'd32: cbp_o = 6'd8;
            6'd33: cbp_o = 6'd17;  6'd34: cbp_o = 6'd18;  6'd35: cbp_o = 6'd20;
            6'd36: cbp_o = 6'd24;  6'd37: cbp_o = 6'd6;   6'd38: cbp_o = 6'd9;
            6'd39: cbp_o = 6'd22;  6'd40: cbp_o = 6'd25;  6'd41: cbp_o = 6'd32;
            6'd42: cbp_o = 6'd33;  6'd43: cbp_o = 6'd34;  6'd44: cbp_o = 6'd36;
            6'd45: cbp_o = 6'd40;  6'd46: cbp_o = 6'd38;  6'd47: cbp_o = 6'd41;
            default: cbp_o = 6'd0;
        endcase
    end

endmodule

// File: rtl/cbp_dec.sv
// -----------------------------------------------------------------------------
// cbp_dec
//   Bit-serial ue(v) parser for the intra coded_block_pattern syntax element.
//   One start_i pulse parses one Exp-Golomb code from the bit stream, maps the
//   codeNum through cbp_dec_lut and presents the result with a valid/ready
//   handshake. Over-long prefixes and codeNums above MAX_CODENUM raise a
//   one-cycle err_o pulse instead of a result.
//
//   Parameters:
//     MAX_LZ       maximum number of prefix zeros accepted (<= 5)
//     MAX_CODENUM  largest legal codeNum
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     start_i      in   begin parsing one element (honoured in IDLE only)
//     bit_i        in   next bitstream bit, MSB first
//     bit_valid_i  in   bit_i is valid
//     bit_ready_o  out  bit_i is consumed this cycle when bit_valid_i is high
//     cbp_o        out  [5:0] coded_block_pattern
//     codenum_o    out  [5:0] decoded codeNum
//     bits_used_o  out  [3:0] bits consumed by the code, 1..11
//     cbp_valid_o  out  result valid, held until cbp_ready_i
//     cbp_ready_i  in   downstream accepts the result
//     err_o        out  one-cycle pulse on an illegal code
//     busy_o       out  block is not idle
// -----------------------------------------------------------------------------
module cbp_dec
    import cbp_dec_pkg::*;
#(
    parameter int MAX_LZ      = CBP_MAX_LZ,
    parameter int MAX_CODENUM = CBP_MAX_CODENUM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    output logic       bit_ready_o,
    output logic [5:0] cbp_o,
    output logic [5:0] codenum_o,
    output logic [3:0] bits_used_o,
    output logic       cbp_valid_o,
    input  logic       cbp_ready_i,
    output logic       err_o,
    output logic       busy_o
);

    state_t            state;
    logic [LZ_W-1:0]   lz;
    logic [LZ_W-1:0]   sufcnt;
    logic [3:0]        suffix;     // holds at most lz-1 <= 4 bits between accepts
    logic [CNT_W-1:0]  bitcnt;

    logic [4:0]        suffix_nxt;
    logic [5:0]        codenum_nxt;
    logic [5:0]        lut_cbp;
    logic              last_suffix;

    // Handshake flags decode straight from the state register, so they are
    // glitch-free and low during and right after reset.
    assign bit_ready_o = (state == ST_PREFIX) || (state == ST_SUFFIX);
    assign busy_o      = (state != ST_IDLE);

    // Suffix including the bit on the wire; only meaningful in SUFFIX.
    assign suffix_nxt  = {suffix, bit_i};
    assign last_suffix = ((sufcnt + 3'd1) == lz);

    // A lone '1' in PREFIX is codeNum 0, so the LUT sees 0 there.
    assign codenum_nxt = (state == ST_SUFFIX) ? eg_codenum(lz, suffix_nxt) : 6'd0;

    cbp_dec_lut u_lut (
        .codenum_i (codenum_nxt),
        .cbp_o     (lut_cbp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lz          <= '0;
            sufcnt      <= '0;
            suffix      <= '0;
            bitcnt      <= '0;
            cbp_o       <= '0;
            codenum_o   <= '0;
            bits_used_o <= '0;
            cbp_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_PREFIX;
                        lz     <= '0;
                        sufcnt <= '0;
                        suffix <= '0;
                        bitcnt <= '0;
                    end
                end

                ST_PREFIX: begin
                    if (bit_valid_i) begin
                        bitcnt <= bitcnt + 4'd1;
                        if (!bit_i) begin
                            if (lz == LZ_W'(MAX_LZ)) begin
                                err_o <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                lz <= lz + 3'd1;
                            end
                        end else if (lz == '0) begin
                            // "1": complete code with no suffix
                            codenum_o   <= codenum_nxt;
                            cbp_o       <= lut_cbp;
                            bits_used_o <= bitcnt + 4'd1;
                            cbp_valid_o <= 1'b1;
                            state       <= ST_OUT;
                        end else begin
                            state <= ST_SUFFIX;
                        end
                    end
                end

                ST_SUFFIX: begin
                    if (bit_valid_i) begin
                        bitcnt <= bitcnt + 4'd1;
                        sufcnt <= sufcnt + 3'd1;
                        suffix <= suffix_nxt[3:0];
                        if (last_suffix) begin
                            if (codenum_nxt > 6'(MAX_CODENUM)) begin
                                err_o <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                codenum_o   <= codenum_nxt;
                                cbp_o       <= lut_cbp;
                                bits_used_o <= bitcnt + 4'd1;
                                cbp_valid_o <= 1'b1;
                                state       <= ST_OUT;
                            end
                        end
                    end
                end

                ST_OUT: begin
                    // Results stay registered after the handshake; only the
                    // valid flag drops. start_i here is not looked at.
                    if (cbp_ready_i) begin
                        cbp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbp_dec.sv
module tb_cbp_dec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       bit_i = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       cbp_ready_i = 1'b0;
    logic       bit_ready_o;
    logic [5:0] cbp_o;
    logic [5:0] codenum_o;
    logic [3:0] bits_used_o;
    logic       cbp_valid_o;
    logic       err_o;
    logic       busy_o;

    cbp_dec #(.MAX_LZ(5), .MAX_CODENUM(47)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .cbp_o       (cbp_o),
        .codenum_o   (codenum_o),
        .bits_used_o (bits_used_o),
        .cbp_valid_o (cbp_valid_o),
        .cbp_ready_i (cbp_ready_i),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Encoder direction: intra CBP value -> codeNum. The bench inverts it.
    int enc_tab [48] = '{ 3, 29, 30, 17, 31, 18, 37,  8, 32, 38, 19,  9,
                         20, 10, 11,  2, 16, 33, 34, 21, 35, 22, 39,  4,
                         36, 40, 23,  5, 24,  6,  7,  1, 41, 42, 43, 25,
                         44, 26, 46, 12, 45, 47, 27, 13, 28, 14, 15,  0};

    typedef struct {
        bit   valid;
        bit   err;
        int   cbp;
        int   cn;
        int   used;
        int   consumed;
    } res_t;

    typedef struct {
        string       nm;
        logic [15:0] bits;
        int          n;
        int          vpct;
        int          rdly;
        bit          sah;
        bit          exp_err;
        int          exp_cn;
        int          exp_cbp;
        int          exp_used;
    } vec_t;

    vec_t vt[$];

    function automatic int ref_cbp(input int cn);
        for (int c = 0; c < 48; c++)
            if (enc_tab[c] == cn) return c;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Parse one element: bits are right-aligned, sent MSB first, each offered
    // with probability vpct%. ready is withheld for rdly cycles once valid.
    task automatic decode(input string nm, input logic [15:0] bits, input int n,
                          input int vpct, input int rdly, input bit sah,
                          output res_t r);
        int idx;
        bit done;
        r = '{default: 0};
        cbp_ready_i = (rdly == 0);
        @(negedge clk);
        start_i = 1'b1;
        bit_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        idx = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (err_o) begin
                r.err = 1'b1;
                r.valid = cbp_valid_o;
                done = 1'b1;
            end else if (cbp_valid_o) begin
                r.valid = 1'b1;
                r.cbp = int'(cbp_o);
                r.cn = int'(codenum_o);
                r.used = int'(bits_used_o);
                done = 1'b1;
            end else begin
                if (idx < n) begin
                    bit_valid_i = ($urandom_range(0, 99) < vpct);
                    bit_i = bits[n-1-idx];
                end else begin
                    bit_valid_i = 1'b1;
                    bit_i = 1'($urandom_range(0, 1));
                end
                if (bit_ready_o && bit_valid_i) idx++;
                @(negedge clk);
            end
        end
        r.consumed = idx;
        chk({nm, " finished"}, 32'(done), 32'd1);
        if (r.err) begin
            bit_valid_i = 1'b0;
            cbp_ready_i = 1'b0;
            @(negedge clk);
            chk({nm, " err one-cycle"}, 32'(err_o), 32'd0);
            chk({nm, " idle after err"}, 32'(busy_o), 32'd0);
        end else if (r.valid) begin
            // keep bits on offer: none may be taken while the result waits
            bit_valid_i = 1'b1;
            for (int k = 0; k < rdly; k++) begin
                @(negedge clk);
                chk({nm, " hold valid"}, 32'(cbp_valid_o), 32'd1);
                chk({nm, " hold cbp"}, 32'(cbp_o), 32'(r.cbp));
                chk({nm, " hold codenum"}, 32'(codenum_o), 32'(r.cn));
                chk({nm, " hold bit_ready"}, 32'(bit_ready_o), 32'd0);
            end
            cbp_ready_i = 1'b1;
            start_i = sah;
            @(negedge clk);
            start_i = 1'b0;
            cbp_ready_i = 1'b0;
            bit_valid_i = 1'b0;
            chk({nm, " valid drop"}, 32'(cbp_valid_o), 32'd0);
            chk({nm, " idle after hs"}, 32'(busy_o), 32'd0);
        end
        bit_valid_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst cbp", 32'(cbp_o), 32'd0);
        chk("rst codenum", 32'(codenum_o), 32'd0);
        chk("rst bits_used", 32'(bits_used_o), 32'd0);
        chk("rst valid", 32'(cbp_valid_o), 32'd0);
        chk("rst err", 32'(err_o), 32'd0);
        chk("rst bit_ready", 32'(bit_ready_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        bit_valid_i = 1'b1;
        @(negedge clk);
        chk("post-rst bit_ready", 32'(bit_ready_o), 32'd0);
        bit_valid_i = 1'b0;

        // directed table
        vt.push_back('{"one",      16'b1,           1, 100, 0, 0, 0,  0, 47,  1});
        vt.push_back('{"cn3",      16'b00100,       5, 100, 1, 0, 0,  3,  0,  5});
        vt.push_back('{"cn29",     16'b000011110,   9, 100, 2, 1, 0, 29,  1,  9});
        vt.push_back('{"cn47_gap", 16'b00000110000, 11, 50, 0, 0, 0, 47, 41, 11});
        vt.push_back('{"ovf",      16'b0,           6, 100, 0, 0, 1,  0,  0,  0});
        vt.push_back('{"cn48",     16'b00000110001, 11,100, 0, 0, 1,  0,  0,  0});
        vt.push_back('{"cn62",     16'b00000111111, 11, 70, 0, 0, 1,  0,  0,  0});
        vt.push_back('{"cn1",      16'b010,         3, 100, 0, 1, 0,  1, 31,  3});
        vt.push_back('{"hold5",    16'b011,         3, 100, 5, 0, 0,  2, 15,  3});

        foreach (vt[i]) begin
            decode(vt[i].nm, vt[i].bits, vt[i].n, vt[i].vpct, vt[i].rdly, vt[i].sah, r);
            chk({vt[i].nm, " err"}, 32'(r.err), 32'(vt[i].exp_err));
            chk({vt[i].nm, " valid"}, 32'(r.valid), 32'(!vt[i].exp_err));
            chk({vt[i].nm, " consumed"}, 32'(r.consumed), 32'(vt[i].n));
            if (!vt[i].exp_err) begin
                chk({vt[i].nm, " codenum"}, 32'(r.cn), 32'(vt[i].exp_cn));
                chk({vt[i].nm, " cbp"}, 32'(r.cbp), 32'(vt[i].exp_cbp));
                chk({vt[i].nm, " bits_used"}, 32'(r.used), 32'(vt[i].exp_used));
            end
        end

        // reset in the middle of a suffix: "0001" + one of three suffix bits
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        bit_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bit_i = (k == 3);
            @(negedge clk);
        end
        bit_valid_i = 1'b0;
        chk("midsfx busy", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midsfx rst busy", 32'(busy_o), 32'd0);
        chk("midsfx rst bit_ready", 32'(bit_ready_o), 32'd0);
        chk("midsfx rst valid", 32'(cbp_valid_o), 32'd0);
        chk("midsfx rst cbp", 32'(cbp_o), 32'd0);
        chk("midsfx rst codenum", 32'(codenum_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        decode("after rst", 16'b1, 1, 100, 0, 0, r);
        chk("after rst cbp", 32'(r.cbp), 32'd47);
        chk("after rst valid", 32'(r.valid), 32'd1);

        // randomized codes against the arithmetic model
        for (int t = 0; t < 40; t++) begin
            int cn, lz, n, rd, vp;
            bit ovf, xerr;
            logic [15:0] b;
            ovf = ($urandom_range(0, 9) == 0);
            cn = $urandom_range(0, 62);
            vp = $urandom_range(30, 100);
            rd = $urandom_range(0, 3);
            if (ovf) begin
                b = 16'd0;
                n = 6;
            end else begin
                lz = 0;
                while (((cn + 1) >> (lz + 1)) != 0) lz++;
                b = 16'(cn + 1);        // codeword is cn+1 behind lz zeros
                n = 2 * lz + 1;
            end
            xerr = ovf || (cn > 47);
            decode("rand", b, n, vp, rd, 1'($urandom_range(0, 1)), r);
            chk("rand err", 32'(r.err), 32'(xerr));
            chk("rand consumed", 32'(r.consumed), 32'(n));
            if (!xerr) begin
                chk("rand codenum", 32'(r.cn), 32'(cn));
                chk("rand cbp", 32'(r.cbp), 32'(ref_cbp(cn)));
                chk("rand bits_used", 32'(r.used), 32'(n));
            end
        end

        // every CBP value round-trips through its encoded codeNum
        for (int c = 0; c < 48; c++) begin
            int cn, lz;
            cn = enc_tab[c];
            lz = 0;
            while (((cn + 1) >> (lz + 1)) != 0) lz++;
            decode("sweep", 16'(cn + 1), 2 * lz + 1, 100, 0, 0, r);
            chk("sweep cbp", 32'(r.cbp), 32'(c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
